// File: rtl/run_ctrl.sv
// Run controller: button-driven program-counter sequencer with single-step,
// slow/fast free-run, halt and an address breakpoint.
module run_ctrl #(
    parameter int DIV_SLOW = 25000000,
    parameter int DIV_FAST = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_btn,
    input  logic       run_btn,
    input  logic       fast_btn,
    input  logic       halt_btn,
    input  logic [7:0] step,
    input  logic       mode,
    input  logic [7:0] value,
    input  logic       bp_en,
    input  logic [7:0] bp_addr,
    output logic [7:0] pc,
    output logic       pc_we,
    output logic [1:0] state,
    output logic       break_hit
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAST  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [25:0] SLOW_LAST = 26'(DIV_SLOW - 1);
    localparam logic [25:0] FAST_LAST = 26'(DIV_FAST - 1);

    // Button bit order: 3 halt, 2 next, 1 fast, 0 run
    logic [3:0]  btn_raw_s;
    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [3:0]  sync3_q;
    logic [3:0]  ev_s;
    logic        ev_halt_s;
    logic        ev_next_s;
    logic        ev_fast_s;
    logic        ev_run_s;

    state_t      state_q;
    state_t      state_d;
    logic [25:0] div_q;
    logic [25:0] div_d;
    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic        pc_we_q;
    logic        pc_we_d;
    logic        brk_q;
    logic        brk_d;
    logic [7:0]  adv_val_s;
    logic [25:0] div_last_s;
    logic        tick_s;

    assign btn_raw_s = {halt_btn, next_btn, fast_btn, run_btn};

    // Synchronizer chain plus edge-detect flop for every button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            sync3_q <= 4'b0000;
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // One-cycle events, masked so only the highest-priority one survives
    assign ev_s      = sync2_q & ~sync3_q;
    assign ev_halt_s = ev_s[3];
    assign ev_next_s = ev_s[2] & ~ev_s[3];
    assign ev_fast_s = ev_s[1] & ~ev_s[2] & ~ev_s[3];
    assign ev_run_s  = ev_s[0] & ~ev_s[1] & ~ev_s[2] & ~ev_s[3];

    assign adv_val_s  = mode ? value : (pc_q + step);
    assign div_last_s = (state_q == ST_FAST) ? FAST_LAST : SLOW_LAST;
    assign tick_s     = (div_q == div_last_s);

    // Next-state, divider and advance decision
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pc_d    = pc_q;
        pc_we_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_BREAK: begin
                div_d = 26'd0;
                if (ev_halt_s) begin
                    state_d = ST_IDLE;
                end else if (ev_next_s) begin
                    state_d = ST_IDLE;
                    pc_d    = adv_val_s;
                    pc_we_d = 1'b1;
                end else if (ev_fast_s) begin
                    state_d = ST_FAST;
                end else if (ev_run_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN, ST_FAST: begin
                // A pending next event swallows fast/run via the priority mask
                if (ev_halt_s) begin
                    state_d = ST_IDLE;
                    div_d   = 26'd0;
                end else if (ev_fast_s && (state_q == ST_RUN)) begin
                    state_d = ST_FAST;
                    div_d   = 26'd0;
                end else if (ev_run_s && (state_q == ST_FAST)) begin
                    state_d = ST_RUN;
                    div_d   = 26'd0;
                end else if (tick_s) begin
                    div_d   = 26'd0;
                    pc_d    = adv_val_s;
                    pc_we_d = 1'b1;
                    if (bp_en && (adv_val_s == bp_addr)) begin
                        state_d = ST_BREAK;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    div_d = div_q + 26'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = 26'd0;
            end
        endcase
        brk_d = (state_d == ST_BREAK);
    end

    // Architectural state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= 26'd0;
            pc_q    <= 8'h00;
            pc_we_q <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pc_q    <= pc_d;
            pc_we_q <= pc_we_d;
            brk_q   <= brk_d;
        end
    end

    assign pc        = pc_q;
    assign pc_we     = pc_we_q;
    assign state     = state_q;
    assign break_hit = brk_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl with DIV_SLOW = 8 and DIV_FAST = 2.
`timescale 1ns/1ps
module tb_run_ctrl;

    localparam int DS = 8;
    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       next_b = 1'b0;
    logic       run_b = 1'b0;
    logic       fast_b = 1'b0;
    logic       halt_b = 1'b0;
    logic [7:0] step = 8'h00;
    logic       mode = 1'b0;
    logic [7:0] value = 8'h00;
    logic       bp_en = 1'b0;
    logic [7:0] bp_addr = 8'h00;
    logic [7:0] pc;
    logic       pc_we;
    logic [1:0] state;
    logic       break_hit;

    int         vectors = 0;
    int         miscompares = 0;
    int         strobes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mpc = 8'h00;
    logic [7:0] sb_e;

    run_ctrl #(.DIV_SLOW(DS), .DIV_FAST(DF)) dut (
        .clk(clk), .rst(rst),
        .next_btn(next_b), .run_btn(run_b), .fast_btn(fast_b), .halt_btn(halt_b),
        .step(step), .mode(mode), .value(value),
        .bp_en(bp_en), .bp_addr(bp_addr),
        .pc(pc), .pc_we(pc_we), .state(state), .break_hit(break_hit)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every pc_we strobe must match the next expected pc
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && pc_we === 1'b1) begin
                strobes++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: strobe with pc=%h, none expected", pc);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (pc !== sb_e) begin
                        miscompares++;
                        $display("FAIL sb_pc: pc=%h required %h", pc, sb_e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_adv();
        mpc = mode ? value : (mpc + step);
        exp_q.push_back(mpc);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: run_b = v;
            1: fast_b = v;
            2: next_b = v;
            3: halt_b = v;
            default: ;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        tick(3);
        set_btn(idx, 1'b0);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (state === s);
    endtask

    task automatic load(input logic [7:0] v);
        mode = 1'b1;
        value = v;
        expect_adv();
        press(2);
        vectors++;
        if (pc !== v) begin miscompares++; $display("FAIL load_pc: pc=%h required %h", pc, v); end
        mode = 1'b0;
        tick(3);
    endtask

    // Called on the sample right after a run-state strobe
    task automatic halt_from_run(input int div, input string tag);
        int s0;
        if (div == 2) expect_adv();
        press(3);
        vectors++;
        if (state !== 2'b00) begin miscompares++; $display("FAIL %s_halt_state: state=%b required 00", tag, state); end
        vectors++;
        if (pc !== mpc) begin miscompares++; $display("FAIL %s_halt_pc: pc=%h required %h", tag, pc, mpc); end
        s0 = strobes;
        tick(10);
        vectors++;
        if (strobes !== s0 || pc !== mpc) begin
            miscompares++;
            $display("FAIL %s_frozen: pc=%h strobes=%0d required pc=%h strobes=%0d", tag, pc, strobes, mpc, s0);
        end
    endtask

    task automatic run_and_halt(input int idx, input int div, input int n, input bit hold, input string tag);
        bit ok;
        logic [1:0] target;
        target = (idx == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < n; i++) expect_adv();
        set_btn(idx, 1'b1);
        wait_state(target, 10, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL %s_enter: state=%b required %b", tag, state, target); end
        if (!hold) set_btn(idx, 1'b0);
        for (int k = 1; k <= n * div; k++) begin
            tick(1);
            vectors++;
            if (pc_we !== ((k % div) == 0) || state !== target) begin
                miscompares++;
                $display("FAIL %s_cadence: cycle %0d pc_we=%b state=%b required pc_we=%b state=%b",
                         tag, k, pc_we, state, ((k % div) == 0), target);
            end
        end
        halt_from_run(div, tag);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (pc !== 8'h00 || pc_we !== 1'b0 || state !== 2'b00 || break_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: pc=%h we=%b state=%b brk=%b required 00 0 00 0", pc, pc_we, state, break_hit);
        end
        tick(3);
        rst = 1'b1;
        tick(4);
        vectors++;
        if (state !== 2'b00 || pc_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: state=%b we=%b required 00 0", state, pc_we);
        end
    endtask

    task automatic test_next();
        int s0;
        step = 8'h03;
        mode = 1'b0;
        mpc = 8'h00;
        for (int i = 1; i <= 2; i++) begin
            s0 = strobes;
            expect_adv();
            press(2);
            vectors++;
            if (pc !== mpc || state !== 2'b00) begin
                miscompares++;
                $display("FAIL next_%0d: pc=%h state=%b required %h 00", i, pc, state, mpc);
            end
            tick(3);
            vectors++;
            if (strobes - s0 !== 1) begin miscompares++; $display("FAIL next_strobes: got %0d required 1", strobes - s0); end
        end
        load(8'h40);
        step = 8'h00;
        s0 = strobes;
        expect_adv();
        press(2);
        tick(3);
        vectors++;
        if (strobes - s0 !== 1 || pc !== 8'h40) begin
            miscompares++;
            $display("FAIL next_step0: strobes=%0d pc=%h required 1 40", strobes - s0, pc);
        end
        step = 8'h03;
    endtask

    task automatic test_run();
        load(8'h00);
        run_and_halt(0, DS, 3, 1'b0, "run");
    endtask

    task automatic test_switch();
        bit ok;
        expect_adv();
        expect_adv();
        set_btn(0, 1'b1);
        wait_state(2'b01, 10, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL sw_run: state=%b required 01", state); end
        set_btn(0, 1'b0);
        tick(3);
        set_btn(1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            vectors++;
            if (pc_we !== 1'b0) begin miscompares++; $display("FAIL sw_quiet: cycle %0d pc_we=%b required 0", k, pc_we); end
        end
        set_btn(1, 1'b0);
        vectors++;
        if (state !== 2'b10) begin miscompares++; $display("FAIL sw_fast: state=%b required 10", state); end
        for (int k = 1; k <= 2 * DF; k++) begin
            tick(1);
            vectors++;
            if (pc_we !== ((k % DF) == 0)) begin
                miscompares++;
                $display("FAIL sw_cadence: cycle %0d pc_we=%b required %b", k, pc_we, ((k % DF) == 0));
            end
        end
        halt_from_run(DF, "sw");
    endtask

    task automatic test_wrap();
        load(8'hFE);
        step = 8'h03;
        run_and_halt(1, DF, 2, 1'b0, "wrap");
        vectors++;
        if (pc !== 8'h07) begin miscompares++; $display("FAIL wrap_pc: pc=%h required 07", pc); end
    endtask

    task automatic test_break();
        bit ok;
        load(8'h00);
        step = 8'h03;
        bp_en = 1'b1;
        bp_addr = 8'h09;
        expect_adv();
        expect_adv();
        expect_adv();
        press(0);
        wait_state(2'b11, 40, ok);
        vectors++;
        if (!ok || pc !== 8'h09 || break_hit !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hit: state=%b pc=%h brk=%b required 11 09 1", state, pc, break_hit);
        end
        tick(20);
        vectors++;
        if (pc !== 8'h09 || state !== 2'b11) begin
            miscompares++;
            $display("FAIL bp_hold: pc=%h state=%b required 09 11", pc, state);
        end
        expect_adv();
        press(2);
        vectors++;
        if (pc !== 8'h0C || state !== 2'b00 || break_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_leave: pc=%h state=%b brk=%b required 0C 00 0", pc, state, break_hit);
        end
        tick(3);
        bp_addr = 8'h0F;
        expect_adv();
        press(2);
        tick(1);
        vectors++;
        if (pc !== 8'h0F || state !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_step_ignored: pc=%h state=%b required 0F 00", pc, state);
        end
        bp_en = 1'b0;
        tick(3);
    endtask

    task automatic test_priority_hold();
        int s0;
        logic [7:0] p0;
        s0 = strobes;
        p0 = pc;
        halt_b = 1'b1;
        next_b = 1'b1;
        tick(3);
        halt_b = 1'b0;
        next_b = 1'b0;
        tick(3);
        vectors++;
        if (strobes !== s0 || pc !== p0 || state !== 2'b00) begin
            miscompares++;
            $display("FAIL prio_halt_next: strobes=%0d pc=%h state=%b required %0d %h 00", strobes, pc, state, s0, p0);
        end
        run_and_halt(0, DS, 12, 1'b1, "hold");
        vectors++;
        if (state !== 2'b00) begin miscompares++; $display("FAIL hold_single_event: state=%b required 00", state); end
        run_b = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_fast();
        bit ok;
        expect_adv();
        expect_adv();
        fast_b = 1'b1;
        wait_state(2'b10, 10, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rf_enter: state=%b required 10", state); end
        tick(2 * DF);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (pc !== 8'h00 || state !== 2'b00 || pc_we !== 1'b0 || break_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL rf_async: pc=%h state=%b we=%b brk=%b required 00 00 0 0", pc, state, pc_we, break_hit);
        end
        mpc = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            vectors++;
            if (pc_we !== 1'b0 || pc !== 8'h00) begin
                miscompares++;
                $display("FAIL rf_in_reset: pc=%h we=%b required 00 0", pc, pc_we);
            end
        end
        rst = 1'b1;
        run_and_halt(1, DF, 2, 1'b1, "rf");
        fast_b = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_next();
        test_run();
        test_switch();
        test_wrap();
        test_break();
        test_priority_hold();
        test_reset_fast();
        tick(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d expected strobes missing, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
